// File: rtl/isqrt_pkg.sv
// Shared widths and per-stage state for the pipelined integer square root.
// Used by isqrt_if, isqrt_slice and isqrt_pipelined (optional remainder: ISQRT_REMAINDER_EN).
package isqrt_pkg;

  localparam int ISQRT_X_W   = 32;
  localparam int ISQRT_Y_W   = 16;
  localparam int ISQRT_REM_W = 17;
  localparam int ISQRT_ACC_W = 34;

  // rem holds the partial remainder with the not-yet-consumed radicand bits below it
  typedef struct packed {
    logic                   valid;
    logic [ISQRT_ACC_W-1:0] rem;
    logic [ISQRT_Y_W-1:0]   root;
  } isqrt_stage_t;

endpackage

// File: rtl/isqrt_if.sv
// Operand/result bundle for isqrt_pipelined; y_rem only exists with ISQRT_REMAINDER_EN.
interface isqrt_if;
  import isqrt_pkg::*;

  logic                   x_vld;
  logic [ISQRT_X_W-1:0]   x;
  logic                   y_vld;
  logic [ISQRT_Y_W-1:0]   y;
`ifdef ISQRT_REMAINDER_EN
  logic [ISQRT_REM_W-1:0] y_rem;
`endif

  modport master (
    output x_vld,
    output x,
    input  y_vld,
    input  y
`ifdef ISQRT_REMAINDER_EN
    , input y_rem
`endif
  );

  modport slave (
    input  x_vld,
    input  x,
    output y_vld,
    output y
`ifdef ISQRT_REMAINDER_EN
    , output y_rem
`endif
  );

endinterface

// File: rtl/isqrt_slice.sv
// One restoring square-root iteration: brings down two radicand bits and decides one root bit.
module isqrt_slice
  import isqrt_pkg::*;
(
  input  isqrt_stage_t stage_i,
  input  logic [3:0]   iter_i,
  output isqrt_stage_t stage_o
);

  logic [5:0]             shamt;
  logic [ISQRT_ACC_W-1:0] trial;
  logic                   fits;

  // The radicand never moves; instead the trial (4*root+1) is aligned to the bit pair of this iteration
  always_comb begin
    shamt         = 6'd30 - {1'b0, iter_i, 1'b0};
    trial         = ISQRT_ACC_W'({stage_i.root, 2'b01}) << shamt;
    fits          = (stage_i.rem >= trial);
    stage_o.valid = stage_i.valid;
    stage_o.rem   = fits ? (stage_i.rem - trial) : stage_i.rem;
    stage_o.root  = {stage_i.root[ISQRT_Y_W-2:0], fits};
  end

endmodule

// File: rtl/isqrt_pipelined.sv
// Pipelined floor(sqrt(x)) with n_pipe_stages register stages, the last one being the output register.
// Define ISQRT_REMAINDER_EN to add the registered y_rem = x - y*y output.
module isqrt_pipelined
  import isqrt_pkg::*;
#(
  parameter int n_pipe_stages = 4
) (
  input logic   clk,
  input logic   rst,
  isqrt_if.slave bus
);

  localparam int ITERS = ISQRT_Y_W / n_pipe_stages;

  isqrt_stage_t stageIn [n_pipe_stages];

  assign stageIn[0] = '{valid: bus.x_vld, rem: {2'b00, bus.x}, root: '0};

  for (genvar s = 0; s < n_pipe_stages; s++) begin : gStage
    isqrt_stage_t chain [ITERS+1];
    isqrt_stage_t stage_d;

    assign chain[0] = stageIn[s];

    for (genvar k = 0; k < ITERS; k++) begin : gIter
      isqrt_slice uSlice (
        .stage_i (chain[k]),
        .iter_i  (4'(s * ITERS + k)),
        .stage_o (chain[k+1])
      );
    end

    assign stage_d = chain[ITERS];

    if (s < n_pipe_stages - 1) begin : gMid
      logic                   valid_q;
      logic [ISQRT_ACC_W-1:0] rem_q;
      logic [ISQRT_Y_W-1:0]   root_q;

      always_ff @(posedge clk) begin
        if (rst) valid_q <= 1'b0;
        else     valid_q <= stage_d.valid;
      end

      // Data is deliberately not reset; it only moves when it carries a valid operand
      always_ff @(posedge clk) begin
        if (stage_d.valid) begin
          rem_q  <= stage_d.rem;
          root_q <= stage_d.root;
        end
      end

      assign stageIn[s+1] = '{valid: valid_q, rem: rem_q, root: root_q};
    end else begin : gOut
      logic                 yVld_q;
      logic [ISQRT_Y_W-1:0] y_q;
      logic                 unusedRemHi;

      always_ff @(posedge clk) begin
        if (rst) begin
          yVld_q <= 1'b0;
          y_q    <= '0;
        end else begin
          yVld_q <= stage_d.valid;
          if (stage_d.valid) y_q <= stage_d.root;
        end
      end

      assign bus.y_vld = yVld_q;
      assign bus.y     = y_q;

`ifdef ISQRT_REMAINDER_EN
      logic [ISQRT_REM_W-1:0] yRem_q;

      // After the last iteration the remainder is at most 2*y, so it fits the low bits
      always_ff @(posedge clk) begin
        if (rst)                 yRem_q <= '0;
        else if (stage_d.valid)  yRem_q <= stage_d.rem[ISQRT_REM_W-1:0];
      end

      assign bus.y_rem   = yRem_q;
      assign unusedRemHi = ^stage_d.rem[ISQRT_ACC_W-1:ISQRT_REM_W];
`else
      assign unusedRemHi = ^stage_d.rem;
`endif
    end
  end

endmodule
